id_stage: RTL and testbench

ID_STAGE -- requirements
Module: id_stage

---
 rtl/id_pkg.sv | 65 ++++++
 rtl/regfile.sv | 44 ++++
 rtl/id_stage.sv | 130 +++++++++++++
 tb/tb_id_stage.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Shared decode definitions for the pipeline stages: opcodes, funct codes,
// ALU operation classes and the decoded control bundle.
package id_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [5:0] OP_RFORM = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       alusrc;
    logic       regdst;
    logic [1:0] aluop;
    logic       use_rs;
    logic       use_rt;
  } ctrl_t;

  // Unknown opcodes fall through to an all-zero bundle: no writes, no source use.
  function automatic ctrl_t decode(input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_RFORM: begin
        c.regwrite = 1'b1; c.regdst = 1'b1; c.aluop = ALUOP_FUNCT;
        c.use_rs = 1'b1; c.use_rt = 1'b1;
      end
      OP_ADDI: begin
        c.regwrite = 1'b1; c.alusrc = 1'b1; c.aluop = ALUOP_ADD;
        c.use_rs = 1'b1;
      end
      OP_LW: begin
        c.regwrite = 1'b1; c.memread = 1'b1; c.memtoreg = 1'b1;
        c.alusrc = 1'b1; c.aluop = ALUOP_ADD; c.use_rs = 1'b1;
      end
      OP_SW: begin
        c.memwrite = 1'b1; c.alusrc = 1'b1; c.aluop = ALUOP_ADD;
        c.use_rs = 1'b1; c.use_rt = 1'b1;
      end
      OP_BEQ: begin
        c.aluop = ALUOP_SUB; c.use_rs = 1'b1; c.use_rt = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/regfile.sv
// Register file: two asynchronous read ports, one synchronous write port,
// register 0 hard-wired to zero, write-through from the write port.
module regfile
  import id_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [XLEN-1:0]   wd,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  output logic [XLEN-1:0]   rd1,
  output logic [XLEN-1:0]   rd2
);

  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

  logic [XLEN-1:0] mem [NREG];

  // A write landing this cycle is visible to readers before the edge commits it.
  function automatic logic [XLEN-1:0] read_port(input logic [REG_AW-1:0] ra,
                                                input logic [XLEN-1:0]   stored);
    if (ra == '0)                    return '0;
    else if (we && (wa == ra))       return wd;
    else if (int'(ra) < NREG)        return stored;
    else                             return '0;
  endfunction

  assign rd1 = read_port(ra1, mem[ra1[AW-1:0]]);
  assign rd2 = read_port(ra2, mem[ra2[AW-1:0]]);

  // Storage update; register 0 and out-of-range addresses are never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we && (wa != '0) && (int'(wa) < NREG)) begin
      mem[wa[AW-1:0]] <= wd;
    end
  end

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: decode, register read, load-use / branch hazard
// detection, early branch resolution and the ID/EX pipeline register.
module id_stage
  import id_pkg::*;
#(
  parameter int ADR_W = 5,
  parameter int NREG  = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [XLEN-1:0]   INST,
  input  logic [ADR_W-1:0]  NADR,
  input  logic              WB_WE,
  input  logic [REG_AW-1:0] WB_ADR,
  input  logic [XLEN-1:0]   WB_DATA,
  output logic              CTR,
  output logic [ADR_W-1:0]  BADR,
  output logic              STALL,
  output logic [XLEN-1:0]   RD1,
  output logic [XLEN-1:0]   RD2,
  output logic [XLEN-1:0]   IMM,
  output logic [REG_AW-1:0] RT_O,
  output logic [REG_AW-1:0] RD_O,
  output logic [ADR_W-1:0]  NADR_O,
  output logic              REGWRITE,
  output logic              MEMREAD,
  output logic              MEMWRITE,
  output logic              MEMTOREG,
  output logic              ALUSRC,
  output logic              REGDST,
  output logic [1:0]        ALUOP
);

  logic [5:0]        opcode;
  logic [REG_AW-1:0] rs, rt, rd;
  logic [XLEN-1:0]   imm_ext;
  logic [XLEN-1:0]   rs_val, rt_val;
  ctrl_t             ctrl;
  logic              is_beq, hit_ex, hit_mem, taken;

  // The EX-stage instruction is exactly what sits in the output register.
  logic [REG_AW-1:0] ex_dest_p1;
  logic [REG_AW-1:0] mem_dest_p2;
  logic              mem_regwrite_p2, mem_memread_p2;

  assign opcode  = INST[31:26];
  assign rs      = INST[25:21];
  assign rt      = INST[20:16];
  assign rd      = INST[15:11];
  assign imm_ext = {{16{INST[15]}}, INST[15:0]};
  assign ctrl    = decode(opcode);
  assign is_beq  = (opcode == OP_BEQ);

  regfile #(.NREG(NREG)) u_regfile (
    .clk   (CLK),
    .rst_n (RST_N),
    .we    (WB_WE),
    .wa    (WB_ADR),
    .wd    (WB_DATA),
    .ra1   (rs),
    .ra2   (rt),
    .rd1   (rs_val),
    .rd2   (rt_val)
  );

  // True when a source actually read by this instruction matches dest; r0 never matches.
  function automatic logic src_hit(input ctrl_t c, input logic [REG_AW-1:0] s1,
                                   input logic [REG_AW-1:0] s2,
                                   input logic [REG_AW-1:0] dest);
    return (c.use_rs && (s1 != '0) && (s1 == dest)) ||
           (c.use_rt && (s2 != '0) && (s2 == dest));
  endfunction

  assign ex_dest_p1 = REGDST ? RD_O : RT_O;
  assign hit_ex     = src_hit(ctrl, rs, rt, ex_dest_p1);
  assign hit_mem    = src_hit(ctrl, rs, rt, mem_dest_p2);

  // Loads stall any consumer one cycle; BEQ compares in ID so it also waits
  // for ALU results in EX and for loads still in MEM.
  assign STALL = (REGWRITE && hit_ex && (MEMREAD || is_beq)) ||
                 (is_beq && mem_regwrite_p2 && mem_memread_p2 && hit_mem);

  // Reset gates the taken decision so IF keeps sequencing while held in reset.
  assign taken = RST_N && is_beq && !STALL && (rs_val == rt_val);
  assign CTR   = ~taken;
  assign BADR  = NADR + imm_ext[ADR_W-1:0];

  // ---- ID/EX pipeline register: bubble on stall, decoded fields otherwise ----
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N || STALL) begin
      if (!RST_N) begin
        RD1 <= '0; RD2 <= '0; IMM <= '0; RT_O <= '0; RD_O <= '0; NADR_O <= '0;
        REGWRITE <= 1'b0; MEMREAD <= 1'b0; MEMWRITE <= 1'b0; MEMTOREG <= 1'b0;
        ALUSRC <= 1'b0; REGDST <= 1'b0; ALUOP <= '0;
      end else begin
        RD1 <= '0; RD2 <= '0; IMM <= '0; RT_O <= '0; RD_O <= '0; NADR_O <= '0;
        REGWRITE <= 1'b0; MEMREAD <= 1'b0; MEMWRITE <= 1'b0; MEMTOREG <= 1'b0;
        ALUSRC <= 1'b0; REGDST <= 1'b0; ALUOP <= '0;
      end
    end else begin
      RD1      <= rs_val;
      RD2      <= rt_val;
      IMM      <= imm_ext;
      RT_O     <= rt;
      RD_O     <= rd;
      NADR_O   <= NADR;
      REGWRITE <= ctrl.regwrite;
      MEMREAD  <= ctrl.memread;
      MEMWRITE <= ctrl.memwrite;
      MEMTOREG <= ctrl.memtoreg;
      ALUSRC   <= ctrl.alusrc;
      REGDST   <= ctrl.regdst;
      ALUOP    <= ctrl.aluop;
    end
  end

  // ---- EX/MEM tracking: MEM always inherits whatever was in EX ----
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mem_dest_p2     <= '0;
      mem_regwrite_p2 <= 1'b0;
      mem_memread_p2  <= 1'b0;
    end else begin
      mem_dest_p2     <= ex_dest_p1;
      mem_regwrite_p2 <= REGWRITE;
      mem_memread_p2  <= MEMREAD;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed scoreboard bench for id_stage.
module tb_id_stage;

  localparam int ADR_W = 5;

  logic              CLK;
  logic              RST_N;
  logic [31:0]       INST;
  logic [ADR_W-1:0]  NADR;
  logic              WB_WE;
  logic [4:0]        WB_ADR;
  logic [31:0]       WB_DATA;
  logic              CTR, STALL;
  logic [ADR_W-1:0]  BADR, NADR_O;
  logic [31:0]       RD1, RD2, IMM;
  logic [4:0]        RT_O, RD_O;
  logic              REGWRITE, MEMREAD, MEMWRITE, MEMTOREG, ALUSRC, REGDST;
  logic [1:0]        ALUOP;

  id_stage #(.ADR_W(ADR_W), .NREG(32)) dut (
    .CLK(CLK), .RST_N(RST_N), .INST(INST), .NADR(NADR),
    .WB_WE(WB_WE), .WB_ADR(WB_ADR), .WB_DATA(WB_DATA),
    .CTR(CTR), .BADR(BADR), .STALL(STALL),
    .RD1(RD1), .RD2(RD2), .IMM(IMM), .RT_O(RT_O), .RD_O(RD_O), .NADR_O(NADR_O),
    .REGWRITE(REGWRITE), .MEMREAD(MEMREAD), .MEMWRITE(MEMWRITE),
    .MEMTOREG(MEMTOREG), .ALUSRC(ALUSRC), .REGDST(REGDST), .ALUOP(ALUOP)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rt, rd;
    logic [4:0]  nadr;
    logic [7:0]  ctl;
  } out_t;

  out_t        sb[$];
  logic [31:0] shadow [32];
  int          compared   = 0;
  int          mismatched = 0;

  localparam logic [31:0] NOP = 32'hFC00_0000;

  function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
    return {6'b000000, s, t, d, 5'd0, 6'b100000};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t,
                                        input logic [15:0] i);
    return {op, s, t, i};
  endfunction

  function automatic logic [31:0] rdreg(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (WB_WE && WB_ADR == a) return WB_DATA;
    return shadow[a];
  endfunction

  function automatic out_t model(input logic [31:0] inst, input logic [4:0] nadr, input bit stall);
    out_t o;
    o = '0;
    if (stall) return o;
    case (inst[31:26])
      6'b000000: o.ctl = 8'b1000_0110;
      6'b001000: o.ctl = 8'b1000_1000;
      6'b100011: o.ctl = 8'b1101_1000;
      6'b101011: o.ctl = 8'b0010_1000;
      6'b000100: o.ctl = 8'b0000_0001;
      default:   o.ctl = 8'b0000_0000;
    endcase
    o.rd1  = rdreg(inst[25:21]);
    o.rd2  = rdreg(inst[20:16]);
    o.imm  = {{16{inst[15]}}, inst[15:0]};
    o.rt   = inst[20:16];
    o.rd   = inst[15:11];
    o.nadr = nadr;
    return o;
  endfunction

  function automatic out_t dut_out();
    return {RD1, RD2, IMM, RT_O, RD_O, NADR_O,
            REGWRITE, MEMREAD, MEMWRITE, MEMTOREG, ALUSRC, REGDST, ALUOP};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one instruction now, check combinational outputs, then check the
  // registered result one edge later against the scoreboard.
  task automatic do_cycle(input string tag, input logic [31:0] inst, input logic [4:0] nadr,
                          input bit we, input logic [4:0] wa, input logic [31:0] wd,
                          input bit exp_stall, input bit exp_ctr);
    out_t exp, got;
    logic [4:0] badr_exp;
    INST = inst; NADR = nadr; WB_WE = we; WB_ADR = wa; WB_DATA = wd;
    #1;
    badr_exp = nadr + inst[4:0];
    chk($sformatf("%s.stall", tag), STALL, exp_stall);
    chk($sformatf("%s.ctr", tag), CTR, exp_ctr);
    chk($sformatf("%s.badr", tag), BADR, badr_exp);
    sb.push_back(model(inst, nadr, exp_stall));
    @(posedge CLK);
    if (we && wa != 5'd0) shadow[wa] = wd;
    #1;
    if (sb.size() == 0) begin
      chk($sformatf("%s.sb_empty", tag), 1, 0);
    end else begin
      exp = sb.pop_front();
      got = dut_out();
      chk($sformatf("%s.rd1", tag), got.rd1, exp.rd1);
      chk($sformatf("%s.rd2", tag), got.rd2, exp.rd2);
      chk($sformatf("%s.imm", tag), got.imm, exp.imm);
      chk($sformatf("%s.fields", tag), {got.rt, got.rd, got.nadr}, {exp.rt, exp.rd, exp.nadr});
      chk($sformatf("%s.ctl", tag), got.ctl, exp.ctl);
    end
  endtask

  task automatic step(input string tag, input logic [31:0] inst, input logic [4:0] nadr,
                      input bit we, input logic [4:0] wa, input logic [31:0] wd,
                      input bit exp_stall, input bit exp_ctr);
    @(negedge CLK);
    do_cycle(tag, inst, nadr, we, wa, wd, exp_stall, exp_ctr);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) shadow[i] = 32'd0;
    RST_N = 1'b1; INST = itype(6'b000100, 5'd0, 5'd0, 16'd4); NADR = 5'd3;
    WB_WE = 1'b0; WB_ADR = 5'd0; WB_DATA = 32'd0;
    #1 RST_N = 1'b0;
    #11;
    // Held in reset with a BEQ r0,r0 presented: never taken, no stall.
    chk("rst.out", dut_out(), '0);
    chk("rst.stall", STALL, 0);
    chk("rst.ctr", CTR, 1);
    chk("rst.badr", BADR, 5'd7);

    // First edge after release decodes the presented BEQ normally.
    @(negedge CLK);
    RST_N = 1'b1;
    do_cycle("rel_beq", itype(6'b000100, 5'd0, 5'd0, 16'd4), 5'd3, 0, 5'd0, 32'd0, 0, 0);

    step("wb_r9", NOP, 5'd1, 1, 5'd9, 32'h1234_5678, 0, 1);
    step("add_r9r9", rtype(5'd9, 5'd9, 5'd10), 5'd2, 0, 5'd0, 32'd0, 0, 1);
    step("wb_r1", NOP, 5'd3, 1, 5'd1, 32'd5, 0, 1);
    step("wb_r2", NOP, 5'd4, 1, 5'd2, 32'd5, 0, 1);
    step("beq_n3", itype(6'b000100, 5'd1, 5'd2, 16'd4), 5'd3, 0, 5'd0, 32'd0, 0, 0);
    chk("beq_n3.badr7", BADR, 5'd7);
    step("beq_n30", itype(6'b000100, 5'd1, 5'd2, 16'd4), 5'd30, 0, 5'd0, 32'd0, 0, 0);
    chk("beq_n30.badr2", BADR, 5'd2);

    // Load-use: one bubble, then the ADD issues.
    step("lw_r8", itype(6'b100011, 5'd9, 5'd8, 16'd128), 5'd5, 0, 5'd0, 32'd0, 0, 1);
    step("add_stall", rtype(5'd8, 5'd9, 5'd10), 5'd6, 0, 5'd0, 32'd0, 1, 1);
    step("add_issue", rtype(5'd8, 5'd9, 5'd10), 5'd6, 0, 5'd0, 32'd0, 0, 1);

    // ALU result feeding a branch: one stall, resolved on the retry with r1
    // arriving through the write port in the same cycle.
    step("addi_r1", itype(6'b001000, 5'd0, 5'd1, 16'd1), 5'd7, 0, 5'd0, 32'd0, 0, 1);
    step("beq_stall", itype(6'b000100, 5'd1, 5'd2, 16'd4), 5'd5, 0, 5'd0, 32'd0, 1, 1);
    step("beq_resolve", itype(6'b000100, 5'd1, 5'd2, 16'd4), 5'd5, 1, 5'd1, 32'd1, 0, 1);

    // Writes to r0 are dropped.
    step("wb_r0", NOP, 5'd8, 1, 5'd0, 32'hFFFF_FFFF, 0, 1);
    step("add_r0", rtype(5'd0, 5'd0, 5'd11), 5'd9, 0, 5'd0, 32'd0, 0, 1);

    // Load two stages back still stalls a branch.
    step("lw_r3", itype(6'b100011, 5'd0, 5'd3, 16'd0), 5'd10, 0, 5'd0, 32'd0, 0, 1);
    step("nop_gap", NOP, 5'd11, 0, 5'd0, 32'd0, 0, 1);
    step("beq_mem_stall", itype(6'b000100, 5'd3, 5'd0, 16'hFFFF), 5'd12, 0, 5'd0, 32'd0, 1, 1);
    step("beq_mem_go", itype(6'b000100, 5'd3, 5'd0, 16'hFFFF), 5'd12, 0, 5'd0, 32'd0, 0, 0);
    step("sw", itype(6'b101011, 5'd1, 5'd2, 16'd4), 5'd13, 0, 5'd0, 32'd0, 0, 1);

    // Asynchronous reset in the middle of a load-use stall.
    step("lw_r8b", itype(6'b100011, 5'd9, 5'd8, 16'd128), 5'd14, 0, 5'd0, 32'd0, 0, 1);
    @(negedge CLK);
    INST = rtype(5'd8, 5'd9, 5'd10); NADR = 5'd15;
    #1;
    chk("midstall.stall", STALL, 1);
    #2;
    RST_N = 1'b0;
    #1;
    chk("midrst.out", dut_out(), '0);
    chk("midrst.stall", STALL, 0);
    chk("midrst.ctr", CTR, 1);
    sb.delete();
    for (int i = 0; i < 32; i++) shadow[i] = 32'd0;

    @(negedge CLK);
    RST_N = 1'b1;
    do_cycle("post_rst_add", rtype(5'd9, 5'd9, 5'd10), 5'd16, 0, 5'd0, 32'd0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
